// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, LSB first, one full-subtractor cell plus a registered borrow.
// Optional macro SERIAL_SUB_OVF_EN adds the signed overflow output V.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, d_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a0, b0, d_bit, bo_bit, last;

    assign a0     = a_sr[0];
    assign b0     = b_sr[0];
    assign d_bit  = a0 ^ b0 ^ br;
    assign bo_bit = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    // Sign bits are shifted out of a_sr/b_sr, so keep copies for the overflow rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            V     <= 1'b0;
        end else if (state == IDLE && start) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end else if (state == SHIFT && last) begin
            V <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
        end
    end
`endif

    // D/Bout load only on the final shift so partial results are never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            D    <= '0;
            Bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr <= {d_bit, d_sr[WIDTH-1:1]};
                    br   <= bo_bit;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        D    <= {d_bit, d_sr[WIDTH-1:1]};
                        Bout <= bo_bit;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected results, a negedge monitor pops on done.
// Build with SERIAL_SUB_OVF_EN to also exercise the V output.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             Bin;
    logic             busy, done;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             V;
`endif

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
    } exp_t;

    exp_t sb_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   done_pulses = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_pulses++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sb_D", 32'(D), 32'(e.d));
                checkOutput("sb_Bout", 32'(Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("sb_V", 32'(V), 32'(e.v));
`endif
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge with junk on the operand inputs.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                                 input logic expect_done, input logic [WIDTH-1:0] ed,
                                 input logic eb, input logic ev);
        exp_t e;
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        if (expect_done) begin
            e.d  = ed;
            e.bout = eb;
            e.v  = ev;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        Bin   = 1'($urandom);
    endtask

    // Waits for done (bounded), optionally checks busy length, then steps to the next IDLE negedge.
    task automatic waitDone(input int exp_busy);
        int busy_cnt = 0;
        int cyc      = 0;
        while (cyc < 4 * WIDTH) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cnt++;
            cyc++;
        end
        if (cyc >= 4 * WIDTH) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=none expected=done within %0d cycles", 4 * WIDTH);
        end else if (exp_busy >= 0) begin
            checkOutput("busy_len", 32'(busy_cnt), 32'(exp_busy));
        end
        @(negedge clk);
    endtask

    initial begin
        int pulses_before;
        rst_n = 1'b0;
        start = 1'($urandom);
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        Bin   = 1'($urandom);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_D", 32'(D), 32'h00);
            checkOutput("rst_Bout", 32'(Bout), 32'd0);
            start = 1'($urandom);
            A     = WIDTH'($urandom);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_no_done", 32'(done_pulses), 32'd0);

        // Basic operations
        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0);
        waitDone(WIDTH);
        repeat (3) @(negedge clk);
        checkOutput("hold_D", 32'(D), 32'h1E);

        applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        waitDone(WIDTH);
        applyStimulus(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        waitDone(WIDTH);

        // start pulsed mid-operation must be ignored
        pulses_before = done_pulses;
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        A     = 8'h33;
        B     = 8'h11;
        Bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(-1);
        repeat (12) @(negedge clk);
        checkOutput("ignored_start_pulses", 32'(done_pulses - pulses_before), 32'd1);
        checkOutput("ignored_start_queue", 32'(sb_q.size()), 32'd0);

        // Reset aborts after 4 shifts
        pulses_before = done_pulses;
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_D", 32'(D), 32'h00);
        checkOutput("abort_Bout", 32'(Bout), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h03, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        checkOutput("post_rst_busy", 32'(busy), 32'd1);
        waitDone(WIDTH);
        checkOutput("abort_no_extra_done", 32'(done_pulses - pulses_before), 32'd1);

        // Signed overflow cases (D/Bout checked in every build)
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
        waitDone(WIDTH);
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
        waitDone(WIDTH);

        repeat (4) @(negedge clk);
        checkOutput("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor computing D = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the sequential consumer of our full-subtractor cell: it wraps that cell's logic in a load/shift/complete state machine with a start/done handshake. It trades WIDTH cycles of latency for one-cell area and sits under any datapath that needs word-wide subtraction without a ripple chain.

## Interface
- WIDTH, 8: operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- D  output  WIDTH  registered difference; holds until the next completion.
- Bout  output  1  registered final borrow-out; holds like D.

## Operation
- Internals: shift registers a_sr and b_sr (WIDTH each), d_sr (WIDTH), borrow flop br, and a bit counter cnt of width clog2(WIDTH).
- Per-bit cell: d = a0 ^ b0 ^ br; bo = (~a0 & b0) | (~(a0 ^ b0) & br), where a0 = a_sr[0] and b0 = b_sr[0].
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, load a_sr←A, b_sr←B, br←Bin, cnt←0, then go to SHIFT. Otherwise hold.
- SHIFT: each edge, d_sr←{d, d_sr[WIDTH-1:1]}, a_sr and b_sr shift right by one, br←bo, cnt←cnt+1.
- On the shift with cnt=WIDTH-1: D←{d, d_sr[WIDTH-1:1]}, Bout←bo, then go to DONE.
- DONE: done=1 for this single cycle, then go to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It is not queued. Holding start high re-triggers on the first IDLE cycle.
- A, B and Bin may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. Bout=1 iff A < B + Bin as unsigned values.

## Timing
- Reset values: busy=0, done=0, D=0, Bout=0. State goes to IDLE and all internal registers clear.
- Edge 0 samples start. Edges 1..WIDTH perform the shifts.
- busy is high from edge 0 to edge WIDTH.
- D and Bout update at edge WIDTH. done is high from edge WIDTH to edge WIDTH+1.
- The earliest next accept is edge WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- D and Bout never show partial results. They change only at completion or reset.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values, and no done pulse is produced for the aborted operation.
- Deasserting rst_n returns the block to IDLE. start is honoured from the first clock edge after deassertion.

## Configuration
- SERIAL_SUB_OVF_EN defined: adds an output port V (1 bit), the signed two's-complement overflow flag.
  - Rule: V = (A[MSB] ^ B[MSB]) & (D[MSB] ^ A[MSB]), using the captured A and B.
  - V is registered with D, holds with D, and resets to 0.
  - Captured sign bits are kept in two extra flops.
- SERIAL_SUB_OVF_EN undefined: there is no V port and no sign flops. All other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 with random inputs → busy=0, done=0, D=0x00, Bout=0, and no done pulse follows.
- WIDTH=8, A=0x5A, B=0x3C, Bin=0, start for 1 cycle → busy high for 8 edges, a single done pulse at edge 8, D=0x1E, Bout=0.
- A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1. Then A=0x10, B=0x0F, Bin=1 → D=0x00, Bout=0.
- Pulse start again at edge 3 of an operation with different operands → ignored. The result matches the first operation and exactly one done pulse occurs.
- Assert rst_n low after 4 shifts of A=0xFF, B=0x01 → outputs clear immediately with no done pulse. A new start with A=0x03, B=0x01 then gives D=0x02, Bout=0.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01, Bin=0 → D=0x7F, Bout=0, V=1. Then A=0x05, B=0x03 → D=0x02, V=0.
